// File: rtl/nios_dbg_seq_pkg.sv
// Shared types and constants for the Nios II debug command sequencer.
// The optional mem_ack timeout is enabled by NIOS_DBG_SEQ_TIMEOUT_EN.
package nios_dbg_seq_pkg;

   localparam int JDO_W = 38;
   localparam int CMD_W = JDO_W + 2;

   localparam logic [1:0] IR_OCIMEM  = 2'b00;
   localparam logic [1:0] IR_TRACE   = 2'b01;
   localparam logic [1:0] IR_BREAK   = 2'b10;
   localparam logic [1:0] IR_ILLEGAL = 2'b11;

   localparam int JDO_WRITE      = 37;
   localparam int JDO_LOAD_ADDR  = 36;
   localparam int JDO_BRK_SEL_HI = 33;
   localparam int JDO_BRK_SEL_LO = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_RESP = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic [1:0]       ir;
      logic [JDO_W-1:0] jdo;
   } cmd_t;

endpackage

// File: rtl/nios_dbg_seq_cmd_fifo.sv
// Command queue for the debug sequencer: first-word-fall-through FIFO with
// full/empty flags and a look-ahead empty flag for the ready output.
module nios_dbg_seq_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 40
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic             empty_next
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [AW:0]      count;
   logic [AW:0]      count_next;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign empty = (wr_ptr_reg == rd_ptr_reg);

   assign count      = wr_ptr_reg - rd_ptr_reg;
   assign count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
   assign empty_next = (count_next == '0);

   assign pop_data = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

endmodule

// File: rtl/nios_dbg_cmd_sequencer.sv
// Sysclk-side executor for JTAG debug commands: queues them and drives OCI
// memory, break and trace targets. Optional mem_ack timeout: NIOS_DBG_SEQ_TIMEOUT_EN.
module nios_dbg_cmd_sequencer
   import nios_dbg_seq_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int MEM_AW         = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_ir,
   input  logic [37:0]       cmd_jdo,
   input  logic              err_clr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              brk_wr,
   output logic [1:0]        brk_sel,
   output logic [31:0]       brk_wdata,
   output logic              trc_ctrl_wr,
   output logic [15:0]       trc_ctrl_data,
   output logic [31:0]       mon_dreg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   seq_state_t        state_reg;
   logic [MEM_AW-1:0] addr_ptr_reg;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_empty_next;
   logic [CMD_W-1:0]  fifo_rdata;
   cmd_t              head;
   logic              push;
   logic              pop;
   logic              head_is_access;
   logic              next_idle;
   logic              err_set;
   logic              timeout_hit;
   logic              unused_jdo_bits;

   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && !fifo_full;
   assign pop       = (state_reg == ST_IDLE) && !fifo_empty;

   nios_dbg_seq_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_cmd_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push),
      .push_data  ({cmd_ir, cmd_jdo}),
      .pop        (pop),
      .pop_data   (fifo_rdata),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .empty_next (fifo_empty_next)
   );

   assign head            = cmd_t'(fifo_rdata);
   assign head_is_access  = (head.ir == IR_OCIMEM) && !head.jdo[JDO_LOAD_ADDR];
   assign unused_jdo_bits = ^head.jdo[35:34];

`ifdef NIOS_DBG_SEQ_TIMEOUT_EN
   logic [15:0] to_cnt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         to_cnt_reg <= '0;
      else if (state_reg == ST_MEM)
         to_cnt_reg <= to_cnt_reg + 16'd1;
      else
         to_cnt_reg <= '0;
   end

   // Fires on the TIMEOUT_CYCLES-th MEM cycle; a coincident ack wins.
   assign timeout_hit = (state_reg == ST_MEM) && !mem_ack &&
                        (to_cnt_reg == 16'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      next_idle = 1'b0;
      case (state_reg)
         ST_IDLE: next_idle = !(pop && head_is_access);
         ST_MEM:  next_idle = 1'b0;
         default: next_idle = 1'b1;
      endcase
   end

   assign err_set = (pop && (head.ir == IR_ILLEGAL)) || timeout_hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_IDLE;
         addr_ptr_reg  <= '0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         brk_wr        <= 1'b0;
         brk_sel       <= '0;
         brk_wdata     <= '0;
         trc_ctrl_wr   <= 1'b0;
         trc_ctrl_data <= '0;
         mon_dreg      <= '0;
         monitor_ready <= 1'b1;
         monitor_error <= 1'b0;
      end else begin
         brk_wr        <= 1'b0;
         trc_ctrl_wr   <= 1'b0;
         monitor_ready <= next_idle && fifo_empty_next;

         if (err_set)
            monitor_error <= 1'b1;
         else if (err_clr)
            monitor_error <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               if (pop) begin
                  case (head.ir)
                     IR_OCIMEM: begin
                        if (head.jdo[JDO_LOAD_ADDR]) begin
                           addr_ptr_reg <= head.jdo[MEM_AW-1:0];
                        end else begin
                           mem_req   <= 1'b1;
                           mem_we    <= head.jdo[JDO_WRITE];
                           mem_addr  <= addr_ptr_reg;
                           mem_wdata <= head.jdo[31:0];
                           state_reg <= ST_MEM;
                        end
                     end
                     IR_TRACE: begin
                        trc_ctrl_wr   <= 1'b1;
                        trc_ctrl_data <= head.jdo[15:0];
                     end
                     IR_BREAK: begin
                        brk_wr    <= 1'b1;
                        brk_sel   <= head.jdo[JDO_BRK_SEL_HI:JDO_BRK_SEL_LO];
                        brk_wdata <= head.jdo[31:0];
                     end
                     default: ;
                  endcase
               end
            end
            ST_MEM: begin
               if (mem_ack) begin
                  mem_req      <= 1'b0;
                  addr_ptr_reg <= addr_ptr_reg + 1'b1;
                  state_reg    <= ST_RESP;
                  if (!mem_we)
                     mon_dreg <= mem_rdata;
               end else if (timeout_hit) begin
                  mem_req   <= 1'b0;
                  state_reg <= ST_RESP;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nios_dbg_cmd_sequencer.sv
// Randomised self-checking bench for nios_dbg_cmd_sequencer; expected events are
// computed in command order at enqueue time and matched against DUT activity.
module tb_nios_dbg_cmd_sequencer;

   localparam int TO_CYC = 8;
   localparam int K_MEM = 0, K_BRK = 1, K_TRC = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_ir = 2'b00;
   logic [37:0] cmd_jdo = '0;
   logic        err_clr = 1'b0;
   logic        mem_req, mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        brk_wr;
   logic [1:0]  brk_sel;
   logic [31:0] brk_wdata;
   logic        trc_ctrl_wr;
   logic [15:0] trc_ctrl_data;
   logic [31:0] mon_dreg;
   logic        monitor_ready, monitor_error;

   always #5 clk = ~clk;

   nios_dbg_cmd_sequencer #(
      .FIFO_DEPTH(4), .MEM_AW(8), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_jdo(cmd_jdo), .err_clr(err_clr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .brk_wr(brk_wr), .brk_sel(brk_sel), .brk_wdata(brk_wdata),
      .trc_ctrl_wr(trc_ctrl_wr), .trc_ctrl_data(trc_ctrl_data),
      .mon_dreg(mon_dreg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: expected target events in execution order.
   typedef struct {
      int          kind;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [1:0]  sel;
   } evt_t;

   evt_t       exp_q[$];
   logic [7:0] m_addr = 8'h00;
   bit         m_err = 1'b0;

   function automatic void model_cmd(input logic [1:0] ir, input logic [37:0] jdo);
      evt_t e;
      e.kind = K_MEM; e.we = 1'b0; e.addr = 8'h00; e.data = jdo[31:0]; e.sel = 2'b00;
      case (ir)
         2'b00: begin
            if (jdo[36]) m_addr = jdo[7:0];
            else begin
               e.kind = K_MEM; e.we = jdo[37]; e.addr = m_addr;
               exp_q.push_back(e);
               m_addr = m_addr + 8'd1;
            end
         end
         2'b01: begin e.kind = K_TRC; e.data = {16'h0000, jdo[15:0]}; exp_q.push_back(e); end
         2'b10: begin e.kind = K_BRK; e.sel = jdo[33:32]; exp_q.push_back(e); end
         default: m_err = 1'b1;
      endcase
   endfunction

   function automatic logic [37:0] mk_mem(input logic we, input logic ld, input logic [31:0] d);
      return {we, ld, 4'h0, d};
   endfunction

   // Memory responder: random ack latency, one-cycle ack with random read data.
   bit auto_ack = 1'b1;
   int dly = 0;
   initial begin
      forever begin
         @(posedge clk); #1;
         if (!reset_n) mem_ack = 1'b0;
         else if (mem_ack) mem_ack = 1'b0;
         else if (mem_req && auto_ack) begin
            if (dly <= 0) begin
               mem_ack = 1'b1;
               mem_rdata = $urandom;
               dly = $urandom_range(0, 4);
            end else dly--;
         end
      end
   end

   // Observer: matches strobes and memory requests against the model queue.
   initial begin
      bit          prev_req = 1'b0;
      bit          chk_dreg = 1'b0;
      logic [31:0] exp_dreg = '0;
      logic        cap_we = 1'b0;
      logic [7:0]  cap_addr = '0;
      logic [31:0] cap_wdata = '0;
      evt_t        e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin prev_req = 1'b0; chk_dreg = 1'b0; continue; end
         if (chk_dreg) begin check("mon_dreg", mon_dreg, exp_dreg); chk_dreg = 1'b0; end
         if (mem_req && !prev_req) begin
            $display("mem  we=%0d addr=0x%02h wdata=0x%08h", mem_we, mem_addr, mem_wdata);
            if (exp_q.size() == 0) check("unexpected_mem", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("mem_kind", e.kind, K_MEM);
               check("mem_we", mem_we, e.we);
               check("mem_addr", mem_addr, e.addr);
               if (e.we) check("mem_wdata", mem_wdata, e.data);
            end
            cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
         end else if (mem_req) begin
            check("mem_hold", {mem_we, mem_addr, mem_wdata}, {cap_we, cap_addr, cap_wdata});
         end
         if (mem_req) check("ready_busy", monitor_ready, 0);
         if (mem_req && mem_ack && !mem_we) begin exp_dreg = mem_rdata; chk_dreg = 1'b1; end
         if (brk_wr) begin
            $display("brk  sel=%0d data=0x%08h", brk_sel, brk_wdata);
            if (exp_q.size() == 0) check("unexpected_brk", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("brk_kind", e.kind, K_BRK);
               check("brk_sel", brk_sel, e.sel);
               check("brk_wdata", brk_wdata, e.data);
            end
         end
         if (trc_ctrl_wr) begin
            $display("trc  data=0x%04h", trc_ctrl_data);
            if (exp_q.size() == 0) check("unexpected_trc", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("trc_kind", e.kind, K_TRC);
               check("trc_data", trc_ctrl_data, e.data[15:0]);
            end
         end
         prev_req = mem_req;
      end
   end

   // Call at a negedge; returns at the negedge after the command is accepted.
   task automatic send(input logic [1:0] ir, input logic [37:0] jdo);
      int n = 0;
      cmd_valid = 1'b1; cmd_ir = ir; cmd_jdo = jdo;
      while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
      if (!cmd_ready) begin
         check("send_timeout", 0, 1);
         cmd_valid = 1'b0;
      end else begin
         model_cmd(ir, jdo);
         @(negedge clk);
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      cmd_valid = 1'b0;
      do begin @(negedge clk); n++; end
      while (!(monitor_ready && exp_q.size() == 0) && n < 3000);
      repeat (2) @(negedge clk);
      check({tag, "_ready"}, monitor_ready, 1);
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      int r;
      logic [37:0] j;

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_mon_ready", monitor_ready, 1);
      check("rst_outputs", {mem_req, mem_we, brk_wr, trc_ctrl_wr, monitor_error}, 0);
      check("rst_data", {mem_addr, mon_dreg, brk_sel}, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Load 0x10, write DEADBEEF, then a write that must land at 0x11.
      dly = 3;
      send(2'b00, mk_mem(1'b0, 1'b1, 32'h0000_0010));
      send(2'b00, mk_mem(1'b1, 1'b0, 32'hDEAD_BEEF));
      send(2'b00, mk_mem(1'b1, 1'b0, 32'h0000_0005));
      drain("load_write");

      // Address wrap with two reads.
      send(2'b00, mk_mem(1'b0, 1'b1, 32'h0000_00FF));
      send(2'b00, mk_mem(1'b0, 1'b0, 32'h0));
      send(2'b00, mk_mem(1'b0, 1'b0, 32'h0));
      drain("read_wrap");

      // Back-to-back break then trace strobes.
      send(2'b10, {4'h0, 2'd2, 32'h0000_1234});
      send(2'b01, {22'h0, 16'h00A5});
      cmd_valid = 1'b0;
      cnt = 0;
      while (!brk_wr && cnt < 10) begin @(negedge clk); cnt++; end
      check("b2b_brk_seen", brk_wr, 1);
      @(negedge clk);
      check("b2b_trc_next", trc_ctrl_wr, 1);
      check("b2b_brk_one", brk_wr, 0);
      drain("b2b");

      // Backpressure: one access stalled in MEM, four queued.
      auto_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(2'b00, mk_mem(1'b1, 1'b0, 32'hA000_0000 + i));
         if (i == 3) check("bp_not_full", cmd_ready, 1);
      end
      cmd_valid = 1'b0;
      check("bp_full", cmd_ready, 0);
      check("bp_req", mem_req, 1);
      auto_ack = 1'b1;
      drain("bp");

      // Sticky error, clear, and set-beats-clear.
      send(2'b11, 38'h0);
      drain("illegal");
      check("err_set", monitor_error, 1);
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      check("err_clr", monitor_error, 0);
      send(2'b11, 38'h0);
      err_clr = 1'b1; cmd_valid = 1'b0;
      @(negedge clk);
      err_clr = 1'b0;
      check("err_set_wins", monitor_error, 1);
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      check("err_clr2", monitor_error, 0);
      drain("err");

`ifdef NIOS_DBG_SEQ_TIMEOUT_EN
      auto_ack = 1'b0;
      send(2'b00, mk_mem(1'b1, 1'b0, 32'h7777_7777));
      cmd_valid = 1'b0;
      m_addr = m_addr - 8'd1;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (mem_req) cnt++;
         else if (cnt > 0) break;
      end
      check("to_req_cycles", cnt, TO_CYC);
      check("to_err", monitor_error, 1);
      auto_ack = 1'b1;
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      send(2'b00, mk_mem(1'b1, 1'b0, 32'h8888_8888));
      drain("timeout");
`endif

      // Reset during an access.
      auto_ack = 1'b0;
      send(2'b00, mk_mem(1'b1, 1'b0, 32'h5555_AAAA));
      send(2'b01, {22'h0, 16'h0F0F});
      cmd_valid = 1'b0;
      cnt = 0;
      while (!mem_req && cnt < 10) begin @(negedge clk); cnt++; end
      check("rst_mid_req_seen", mem_req, 1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_req_drop", mem_req, 0);
      @(negedge clk);
      check("rst_mid_cmd_ready", cmd_ready, 1);
      check("rst_mid_mon_ready", monitor_ready, 1);
      exp_q.delete();
      m_addr = 8'h00;
      reset_n = 1'b1;
      auto_ack = 1'b1;
      @(negedge clk);
      send(2'b00, mk_mem(1'b1, 1'b0, 32'h1357_9BDF));
      send(2'b00, mk_mem(1'b0, 1'b0, 32'h0));
      drain("post_rst");

      // Randomised command stream.
      m_err = 1'b0;
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         j = {$urandom, $urandom};
         if (r < 45) begin
            j[36] = ($urandom_range(0, 4) == 0);
            send(2'b00, j);
         end else if (r < 65) send(2'b01, j);
         else if (r < 85) send(2'b10, j);
         else send(2'b11, j);
         if ($urandom_range(0, 2) == 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      drain("random");
      check("random_err", monitor_error, m_err);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/nios_dbg_cmd_sequencer.md
Name: nios_dbg_cmd_sequencer

Overview:
- Sysclk-domain sequencer behind the Nios II debug-slave JTAG bridge.
- Accepts decoded debug commands: a 2-bit IR code plus a 38-bit jdo word, already synchronised into clk.
- Queues the commands and executes them in order against three targets: OCI memory (req/ack handshake), break registers and trace control (one-cycle write strobes).
- Reports results back to the JTAG side through mon_dreg, monitor_ready and monitor_error.

Parameters:
- FIFO_DEPTH, 4, command queue depth; power of 2, minimum 2.
- MEM_AW, 8, OCI memory word-address width.
- TIMEOUT_CYCLES, 255, maximum wait for mem_ack; range 1..65535.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept; equals !full
- cmd_ir  in  2  00 ocimem, 01 trace, 10 break, 11 illegal
- cmd_jdo  in  38  command payload
- err_clr  in  1  one-cycle pulse; clears monitor_error
- mem_req  out  1  OCI memory access request
- mem_we  out  1  write when 1
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  32  write data
- mem_ack  in  1  access complete
- mem_rdata  in  32  read data, valid while mem_ack=1
- brk_wr  out  1  break-register write strobe
- brk_sel  out  2  break register index
- brk_wdata  out  32  break data
- trc_ctrl_wr  out  1  trace-control write strobe
- trc_ctrl_data  out  16  trace-control value
- mon_dreg  out  32  last read data
- monitor_ready  out  1  idle and queue empty
- monitor_error  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1 and monitor_ready=1. FIFO is emptied and the address pointer is set to 0.
- Reset mid-access drops mem_req immediately. The pending command is discarded.
- Enqueue: a command is written when cmd_valid && cmd_ready. There is no bypass.
  - When full, cmd_ready=0 even if a pop happens in the same cycle.
  - Push and pop in the same non-full cycle are both honoured.
- ocimem field layout (ir=00): jdo[37]=write, jdo[36]=load_addr, jdo[31:0]=data.
  - If load_addr=1: addr_ptr <= jdo[MEM_AW-1:0]. No memory access is made.
- FSM states: IDLE, MEM, RESP.
  - IDLE with FIFO non-empty at cycle T: the head is popped at T.
  - ocimem access: mem_req=1 from T+1; mem_we, mem_addr=addr_ptr and mem_wdata=jdo[31:0] are held stable. Next state MEM.
  - trace (ir=01): trc_ctrl_wr=1 for exactly cycle T+1, trc_ctrl_data=jdo[15:0]. FSM stays in IDLE.
  - break (ir=10): brk_wr=1 for exactly cycle T+1, brk_sel=jdo[33:32], brk_wdata=jdo[31:0]. FSM stays in IDLE.
  - illegal (ir=11) or load_addr: no strobe. Illegal sets monitor_error at T+1.
  - IDLE can pop one command per cycle, so back-to-back strobes are allowed.
- MEM state:
  - On the first cycle with mem_ack=1: mem_req deasserts the next cycle.
  - On a read, mon_dreg <= mem_rdata in that cycle.
  - addr_ptr increments modulo 2^MEM_AW, so 0xFF wraps to 0x00.
  - Next state RESP.
- RESP lasts one cycle, then returns to IDLE. No pop happens in RESP.
- mem_ack outside MEM is ignored.
- monitor_ready is registered: 1 iff next state is IDLE and the FIFO will be empty.
- monitor_error is sticky. err_clr clears it. If a set and a clear occur in the same cycle, the set wins.

Optional Feature:
- Macro: NIOS_DBG_SEQ_TIMEOUT_EN.
- Defined: a 16-bit counter runs while in MEM.
  - If the counter reaches TIMEOUT_CYCLES without mem_ack: mem_req drops, monitor_error is set, addr_ptr is unchanged, mon_dreg is unchanged, FSM goes to RESP.
  - An ack arriving in the same cycle as the timeout takes precedence (normal completion).
- Undefined: MEM waits indefinitely. No counter logic is present.

Decomposition:
- Package nios_dbg_seq_pkg holds:
  - IR codes: IR_OCIMEM, IR_TRACE, IR_BREAK, IR_ILLEGAL.
  - FSM state enum.
  - jdo field positions: JDO_WRITE=37, JDO_LOAD_ADDR=36, JDO_BRK_SEL_HI=33, JDO_BRK_SEL_LO=32.
- One sub-module, nios_dbg_seq_cmd_fifo: synchronous FIFO, 40 bits wide, FIFO_DEPTH deep, with full/empty flags.

Test Plan:
- Load and write: ocimem load_addr with jdo[7:0]=0x10, then write 0xDEADBEEF; ack after 3 cycles.
  - Expect mem_addr=0x10, mem_we=1, mem_wdata=0xDEADBEEF held until ack.
  - addr_ptr becomes 0x11; monitor_ready returns to 1.
- Read with wrap: load 0xFF, then read twice; mem_rdata 0x11111111 then 0x22222222.
  - Expect addresses 0xFF then 0x00; mon_dreg ends at 0x22222222.
- Break then trace, back-to-back: break with jdo[33:32]=2, data 0x00001234; then trace with jdo[15:0]=0x00A5.
  - Expect brk_wr for one cycle with brk_sel=2; trc_ctrl_wr on the following cycle with trc_ctrl_data=0x00A5.
- Backpressure: with mem_ack held at 0, push 5 ocimem writes.
  - cmd_ready falls after the 5th accept: one command is in MEM, 4 are queued.
  - Release ack: all 5 writes complete in order.
- Errors: illegal IR sets monitor_error; an err_clr pulse clears it; set+clear in the same cycle leaves it at 1.
  - With NIOS_DBG_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack: mem_req drops after 8 cycles, monitor_error=1.
- Reset mid-access: assert reset_n=0 during MEM.
  - mem_req goes to 0 asynchronously; after release the FIFO is empty, monitor_ready=1, addr_ptr=0.
